ad80305_cfg_seq: RTL and testbench

Power-up configuration sequencer for the two AD80305 chips. It walks a register-init table held in an external ROM and issues one SPI write (or a write then readback-verify) per entry. It drives the single-register read/write request port of the AD80305 SPI driver and ends the run with a done or error status to monitoring logic. It also supports timed delay entries and an end-of-table marker.

---
 rtl/ad80305_cfg_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_ad80305_cfg_seq.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad80305_cfg_seq.sv
// ---------------------------------------------------------------------------
// ad80305_cfg_seq
//
// Power-up configuration sequencer for the two AD80305 chips. Walks a
// register-init table held in an external ROM and issues one SPI write, or a
// write followed by a readback-verify, per entry through the single-register
// request port of the AD80305 SPI driver. Also supports timed delay entries
// and an end-of-table marker. Each run ends with a done or error status.
//
// Table entry layout: {cmd[21:20], chip[19:18], addr[17:8], data[7:0]}
//   cmd 00 write, 01 write + readback-verify, 10 delay data*1024, 11 end.
//
// Ports
//   i_fpga_clk_125p   125 MHz clock
//   i_fpga_rst_125p   asynchronous active-low reset
//   i_start           rising edge starts a run (ignored while o_busy)
//   o_tbl_addr        ROM index; i_tbl_data valid one cycle later
//   i_tbl_data        table entry
//   o_rd_en/o_wr_en   request levels to the SPI driver (edge triggered there)
//   o_mod_sel         constant 000, single-register mode
//   o_chip_sel        00 chip0, 01 chip1, 11 none (reset)
//   o_addr/o_data     register address / write data, sampled live by driver
//   i_rw_result       driver status: 1 idle, 0 transaction in progress
//   i_rw_data         readback byte, valid once i_rw_result returns to 1
//   o_busy            run in progress
//   o_done/o_error    sticky status of the last run
//   o_err_code        01 start timeout, 10 done timeout, 11 verify mismatch
//   o_err_idx         index of the failing entry
// ---------------------------------------------------------------------------
module ad80305_cfg_seq #(
  parameter int TABLE_DEPTH = 64,
  parameter int ADDR_W      = 6,
  parameter int MAX_RETRY   = 3,
  parameter int START_TO    = 32,
  parameter int DONE_TO     = 8191
) (
  input  logic              i_fpga_clk_125p,
  input  logic              i_fpga_rst_125p,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_tbl_addr,
  input  logic [21:0]       i_tbl_data,
  output logic              o_rd_en,
  output logic              o_wr_en,
  output logic [2:0]        o_mod_sel,
  output logic [1:0]        o_chip_sel,
  output logic [9:0]        o_addr,
  output logic [7:0]        o_data,
  input  logic [7:0]        i_rw_result,
  input  logic [7:0]        i_rw_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [1:0]        o_err_code,
  output logic [ADDR_W-1:0] o_err_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_START, S_WAIT_DONE,
    S_GAP, S_CHECK, S_DELAY, S_FINISH, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    CMD_WR        = 2'b00,
    CMD_WR_VERIFY = 2'b01,
    CMD_DELAY     = 2'b10,
    CMD_END       = 2'b11
  } cmd_t;

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [1:0]         ERR_START  = 2'b01;
  localparam logic [1:0]         ERR_DONE   = 2'b10;
  localparam logic [1:0]         ERR_VERIFY = 2'b11;
  localparam logic [12:0]        START_LAST = 13'(START_TO - 1);
  localparam logic [12:0]        DONE_LAST  = 13'(DONE_TO - 1);
  // The enables stay low for this many + 1 cycles between requests.
  localparam logic [12:0]        GAP_LAST   = 13'd3;
  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(TABLE_DEPTH - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

  state_t              state, state_nxt;
  cmd_t                cmd;
  cmd_t                entry_cmd;
  logic [ADDR_W-1:0]   idx;
  logic [12:0]         to_cnt;    // shared by both timeouts and the gap
  logic [17:0]         dly_cnt;
  logic [RETRY_W-1:0]  retry;
  logic                rd_phase;  // 1 while issuing the readback of cmd 01
  logic                start_d1, start_d2;
  logic                start_edge;
  logic                last_entry;

  assign entry_cmd  = cmd_t'(i_tbl_data[21:20]);
  assign start_edge = start_d1 & ~start_d2;
  assign last_entry = (idx == LAST_IDX);
  assign o_tbl_addr = idx;
  assign o_mod_sel  = 3'b000;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start_edge) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (entry_cmd)
          CMD_WR, CMD_WR_VERIFY: state_nxt = S_ISSUE;
          CMD_DELAY:             state_nxt = S_DELAY;
          default:               state_nxt = S_FINISH;
        endcase
      end
      S_ISSUE:  state_nxt = S_WAIT_START;
      S_WAIT_START: begin
        if (i_rw_result == 8'd0)       state_nxt = S_WAIT_DONE;
        else if (to_cnt == START_LAST) state_nxt = S_ERR;
      end
      S_WAIT_DONE: begin
        if (i_rw_result == 8'd1)      state_nxt = S_GAP;
        else if (to_cnt == DONE_LAST) state_nxt = S_ERR;
      end
      S_GAP: begin
        if (to_cnt == GAP_LAST) begin
          if (cmd == CMD_WR_VERIFY) state_nxt = rd_phase ? S_CHECK : S_ISSUE;
          else                      state_nxt = last_entry ? S_FINISH : S_FETCH;
        end
      end
      S_CHECK: begin
        if (i_rw_data == o_data) state_nxt = last_entry ? S_FINISH : S_FETCH;
        else if (retry < RETRY_MAX) state_nxt = S_ISSUE;
        else                        state_nxt = S_ERR;
      end
      S_DELAY:  if (dly_cnt == 18'd0) state_nxt = last_entry ? S_FINISH : S_FETCH;
      S_FINISH: state_nxt = S_IDLE;
      S_ERR:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge i_fpga_clk_125p or negedge i_fpga_rst_125p) begin
    if (!i_fpga_rst_125p) begin
      state      <= S_IDLE;
      cmd        <= CMD_WR;
      idx        <= '0;
      to_cnt     <= '0;
      dly_cnt    <= '0;
      retry      <= '0;
      rd_phase   <= 1'b0;
      start_d1   <= 1'b0;
      start_d2   <= 1'b0;
      o_rd_en    <= 1'b0;
      o_wr_en    <= 1'b0;
      o_chip_sel <= 2'b11;
      o_addr     <= '0;
      o_data     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
      o_err_code <= 2'b00;
      o_err_idx  <= '0;
    end else begin
      state    <= state_nxt;
      start_d1 <= i_start;
      start_d2 <= start_d1;

      // Every wait state starts counting from zero on entry.
      if (state_nxt != state) to_cnt <= '0;
      else if (state inside {S_WAIT_START, S_WAIT_DONE, S_GAP}) to_cnt <= to_cnt + 1'b1;

      // The request level is high exactly while waiting for the driver to
      // report busy; the phase picks which enable.
      o_wr_en <= (state_nxt == S_WAIT_START) && !rd_phase;
      o_rd_en <= (state_nxt == S_WAIT_START) &&  rd_phase;

      if (state == S_IDLE && state_nxt == S_FETCH) begin
        idx        <= '0;
        o_busy     <= 1'b1;
        o_done     <= 1'b0;
        o_error    <= 1'b0;
        o_err_code <= 2'b00;
        o_err_idx  <= '0;
      end else if (state_nxt == S_FETCH) begin
        idx <= idx + 1'b1;
      end

      if (state == S_DECODE) begin
        cmd      <= entry_cmd;
        retry    <= '0;
        rd_phase <= 1'b0;
        if (entry_cmd == CMD_WR || entry_cmd == CMD_WR_VERIFY) begin
          o_chip_sel <= i_tbl_data[19:18];
          o_addr     <= i_tbl_data[17:8];
          o_data     <= i_tbl_data[7:0];
        end
        if (entry_cmd == CMD_DELAY) dly_cnt <= {i_tbl_data[7:0], 10'd0};
      end

      if (state == S_DELAY && dly_cnt != 18'd0) dly_cnt <= dly_cnt - 1'b1;

      if (state == S_GAP && state_nxt == S_ISSUE) rd_phase <= 1'b1;

      if (state == S_CHECK && state_nxt == S_ISSUE) begin
        rd_phase <= 1'b0;
        retry    <= retry + 1'b1;
      end

      if (state_nxt == S_ERR) begin
        unique case (state)
          S_WAIT_START: o_err_code <= ERR_START;
          S_WAIT_DONE:  o_err_code <= ERR_DONE;
          default:      o_err_code <= ERR_VERIFY;
        endcase
      end

      if (state == S_FINISH) begin
        o_busy <= 1'b0;
        o_done <= 1'b1;
      end

      if (state == S_ERR) begin
        o_busy    <= 1'b0;
        o_error   <= 1'b1;
        o_err_idx <= idx;
      end
    end
  end

endmodule

// File: tb/tb_ad80305_cfg_seq.sv
// ---------------------------------------------------------------------------
// tb_ad80305_cfg_seq
//
// Self-checking bench for ad80305_cfg_seq. A ROM model feeds the table, a
// driver model answers requests (with configurable stall and readback
// behaviour) and logs every transaction it accepts. A reference model walks
// the table with plain loops to produce the expected transaction list and
// final status for each run.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ad80305_cfg_seq;

  localparam int DEPTH    = 64;
  localparam int AW       = 6;
  localparam int RETRIES  = 3;
  localparam int BUSY_LEN = 20;

  typedef struct packed {
    logic       rd;
    logic [1:0] chip;
    logic [9:0] addr;
    logic [7:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] tbl_addr;
  logic [21:0]   tbl_data = '0;
  logic          rd_en, wr_en;
  logic [2:0]    mod_sel;
  logic [1:0]    chip_sel;
  logic [9:0]    addr;
  logic [7:0]    data;
  logic [7:0]    rw_result = 8'd1;
  logic [7:0]    rw_data = 8'd0;
  logic          busy, done, error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_idx;

  always #4 clk = ~clk;

  ad80305_cfg_seq dut (
    .i_fpga_clk_125p (clk),
    .i_fpga_rst_125p (rst_n),
    .i_start         (start),
    .o_tbl_addr      (tbl_addr),
    .i_tbl_data      (tbl_data),
    .o_rd_en         (rd_en),
    .o_wr_en         (wr_en),
    .o_mod_sel       (mod_sel),
    .o_chip_sel      (chip_sel),
    .o_addr          (addr),
    .o_data          (data),
    .i_rw_result     (rw_result),
    .i_rw_data       (rw_data),
    .o_busy          (busy),
    .o_done          (done),
    .o_error         (error),
    .o_err_code      (err_code),
    .o_err_idx       (err_idx)
  );

  // ---------------- ROM model ----------------
  logic [21:0] rom [DEPTH];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // ---------------- driver model ----------------
  int   drv_mode  = 0;   // 0 normal, 1 never goes busy, 2 never returns idle
  int   rd_fail_n = 0;   // number of reads per run that return 0x00
  int   run_id    = 0;
  int   seen_run  = 0;
  int   reads_seen = 0;
  int   drv_cnt   = 0;
  bit   active    = 1'b0;
  logic wr_q1 = 1'b0, wr_q2 = 1'b0, rd_q1 = 1'b0, rd_q2 = 1'b0;
  txn_t cur = '0;
  logic [7:0] mem [2][1024];
  txn_t obs_q[$];
  int   done_cyc_q[$];
  int   fall_cyc  = 0;
  int   hold_err  = 0;
  int   cyc       = 0;

  always @(posedge clk) begin
    wr_q1 <= wr_en; wr_q2 <= wr_q1;
    rd_q1 <= rd_en; rd_q2 <= rd_q1;
    if (run_id != seen_run) begin
      seen_run   <= run_id;
      reads_seen <= 0;
    end
    if (!active) begin
      if (drv_mode != 1 && ((wr_q1 && !wr_q2) || (rd_q1 && !rd_q2))) begin
        active  <= 1'b1;
        drv_cnt <= 0;
        cur     <= '{rd: rd_q1 && !rd_q2, chip: chip_sel, addr: addr, data: data};
      end
    end else begin
      drv_cnt <= drv_cnt + 1;
      if (busy && (chip_sel != cur.chip || addr != cur.addr || data != cur.data))
        hold_err <= hold_err + 1;
      if (drv_cnt == 2) begin
        rw_result <= 8'd0;
        fall_cyc  <= cyc;
      end
      if (drv_cnt >= 2 + BUSY_LEN && drv_mode != 2) begin
        rw_result <= 8'd1;
        active    <= 1'b0;
        obs_q.push_back(cur);
        done_cyc_q.push_back(cyc);
        if (cur.rd) begin
          rw_data <= (reads_seen < rd_fail_n) ? 8'h00 : mem[cur.chip[0]][cur.addr];
          if (run_id == seen_run) reads_seen <= reads_seen + 1;
        end else begin
          mem[cur.chip[0]][cur.addr] <= cur.data;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int   wr_rise_q[$];
  logic wr_prev = 1'b0, err_prev = 1'b0;
  int   err_rise_cyc = 0;
  int   both_hi = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    wr_prev  <= wr_en;
    err_prev <= error;
    if (wr_en && !wr_prev) wr_rise_q.push_back(cyc);
    if (error && !err_prev) err_rise_cyc <= cyc;
    if (rd_en && wr_en) both_hi <= both_hi + 1;
  end

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  txn_t       exp_q[$];
  logic       exp_done, exp_err;
  logic [1:0] exp_code;
  logic [5:0] exp_idx;

  task automatic ref_run(input int fail_n);
    int   reads;
    bit   ok;
    logic [21:0] e;
    exp_q.delete();
    reads = 0; exp_done = 1'b1; exp_err = 1'b0; exp_code = 2'b00; exp_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      e = rom[i];
      if (e[21:20] == 2'b11) return;
      if (e[21:20] == 2'b00) exp_q.push_back({1'b0, e[19:0]});
      if (e[21:20] == 2'b01) begin
        ok = 1'b0;
        for (int t = 0; t <= RETRIES && !ok; t++) begin
          exp_q.push_back({1'b0, e[19:0]});
          exp_q.push_back({1'b1, e[19:0]});
          ok = (reads >= fail_n);
          reads++;
        end
        if (!ok) begin
          exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'b11; exp_idx = 6'(i);
          return;
        end
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  int obs_base, done_base, wr_base;

  task automatic set_entry(input int i, input logic [1:0] c, input logic [1:0] ch,
                           input logic [9:0] a, input logic [7:0] d);
    rom[i] = {c, ch, a, d};
  endtask

  task automatic fill_end();
    for (int i = 0; i < DEPTH; i++) rom[i] = {2'b11, 20'h0};
  endtask

  task automatic rand_table(input int end_pos);
    int r;
    logic [1:0] c;
    logic [7:0] d;
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom_range(0, 9);
      c = (r < 6) ? 2'b00 : (r < 9) ? 2'b01 : 2'b10;
      d = (c == 2'b10) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(1, 255));
      rom[i] = {c, 2'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), d};
    end
    if (end_pos < DEPTH) rom[end_pos] = {2'b11, 20'h0};
  endtask

  task automatic start_run(input string tag);
    int n;
    n = 0;
    run_id++;
    obs_base  = obs_q.size();
    done_base = done_cyc_q.size();
    wr_base   = wr_rise_q.size();
    @(negedge clk);
    start = 1'b1;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({tag, ":busy_latency"}, 64'(n), 64'd2);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, ":run_ends"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_ref(input string tag, input int fail_n);
    ref_run(fail_n);
    check({tag, ":done"},     64'(done),     64'(exp_done));
    check({tag, ":error"},    64'(error),    64'(exp_err));
    check({tag, ":err_code"}, 64'(err_code), 64'(exp_code));
    check({tag, ":err_idx"},  64'(err_idx),  64'(exp_idx));
    check({tag, ":n_txn"},    64'(obs_q.size() - obs_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_base + i < obs_q.size())
        check($sformatf("%s:txn%0d", tag, i), 64'(obs_q[obs_base + i]), 64'(exp_q[i]));
    check({tag, ":hold_stable"}, 64'(hold_err), 64'd0);
    check({tag, ":one_enable"},  64'(both_hi),  64'd0);
    check({tag, ":enables_low"}, 64'({rd_en, wr_en}), 64'd0);
  endtask

  function automatic logic [41:0] out_vec();
    return {rd_en, wr_en, mod_sel, chip_sel, addr, data, tbl_addr,
            busy, done, error, err_code, err_idx};
  endfunction

  localparam logic [41:0] RESET_VEC = {1'b0, 1'b0, 3'b000, 2'b11, 10'd0, 8'd0, 6'd0,
                                       1'b0, 1'b0, 1'b0, 2'b00, 6'd0};

  // ---------------- test sequence ----------------
  initial begin
    int lat, n;
    fill_end();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two plain writes then end marker.
    fill_end();
    set_entry(0, 2'b00, 2'b00, 10'h012, 8'hA5);
    set_entry(1, 2'b00, 2'b01, 10'h3FF, 8'h5A);
    start_run("wr2");
    wait_idle("wr2", 2000);
    check_ref("wr2", 0);

    // Verify entry: immediate match, always mismatch, match on second read.
    fill_end();
    set_entry(0, 2'b01, 2'b00, 10'h020, 8'h3C);
    rd_fail_n = 0;
    start_run("vfy_ok");
    wait_idle("vfy_ok", 2000);
    check_ref("vfy_ok", 0);

    rd_fail_n = 1000;
    start_run("vfy_bad");
    wait_idle("vfy_bad", 4000);
    check_ref("vfy_bad", 1000);

    rd_fail_n = 1;
    start_run("vfy_retry");
    wait_idle("vfy_retry", 4000);
    check_ref("vfy_retry", 1);
    rd_fail_n = 0;

    // Driver never reports busy.
    fill_end();
    set_entry(0, 2'b00, 2'b00, 10'h005, 8'h77);
    drv_mode = 1;
    start_run("start_to");
    wait_idle("start_to", 200);
    check("start_to:error", 64'({error, done}), 64'b10);
    check("start_to:err_code", 64'(err_code), 64'd1);
    check("start_to:err_idx", 64'(err_idx), 64'd0);
    check("start_to:enables_low", 64'({rd_en, wr_en}), 64'd0);
    lat = (wr_rise_q.size() > wr_base) ? err_rise_cyc - wr_rise_q[wr_base] : -1;
    check("start_to:latency_32", 64'(lat >= 32 && lat <= 36), 64'd1);
    drv_mode = 0;
    repeat (10) @(negedge clk);

    // Driver never returns idle.
    drv_mode = 2;
    start_run("done_to");
    wait_idle("done_to", 9000);
    check("done_to:error", 64'({error, done}), 64'b10);
    check("done_to:err_code", 64'(err_code), 64'd2);
    check("done_to:enables_low", 64'({rd_en, wr_en}), 64'd0);
    lat = err_rise_cyc - fall_cyc;
    check("done_to:latency_8191", 64'(lat >= 8191 && lat <= 8200), 64'd1);
    drv_mode = 0;
    repeat (60) @(negedge clk);

    // Delay entry between two writes; a start edge mid-run must be dropped.
    fill_end();
    set_entry(0, 2'b00, 2'b00, 10'h010, 8'h11);
    set_entry(1, 2'b10, 2'b00, 10'h000, 8'h02);
    set_entry(2, 2'b00, 2'b01, 10'h011, 8'h22);
    start_run("delay");
    repeat (100) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle("delay", 5000);
    check_ref("delay", 0);
    lat = (wr_rise_q.size() > wr_base + 1 && done_cyc_q.size() > done_base)
          ? wr_rise_q[wr_base + 1] - done_cyc_q[done_base] : -1;
    check("delay:gap_ge_2048", 64'(lat >= 2048), 64'd1);
    repeat (10) @(negedge clk);
    check("delay:no_restart", 64'(busy), 64'd0);

    // Full table, no end marker: all 64 writes then finish at index 63.
    rand_table(DEPTH);
    for (int i = 0; i < DEPTH; i++) rom[i][21:20] = 2'b00;
    start_run("full64");
    wait_idle("full64", 6000);
    check_ref("full64", 0);
    check("full64:last_index", 64'(tbl_addr), 64'd63);

    // Randomized tables with random readback failure counts.
    for (int r = 0; r < 4; r++) begin
      rand_table($urandom_range(4, 14));
      rd_fail_n = $urandom_range(0, 4);
      start_run($sformatf("rand%0d", r));
      wait_idle($sformatf("rand%0d", r), 40000);
      check_ref($sformatf("rand%0d", r), rd_fail_n);
    end
    rd_fail_n = 0;

    // Reset during WAIT_DONE, then restart from index 0.
    fill_end();
    set_entry(0, 2'b00, 2'b00, 10'h012, 8'hA5);
    set_entry(1, 2'b00, 2'b01, 10'h3FF, 8'h5A);
    start_run("rst_mid");
    n = 0;
    while (rw_result != 8'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid:driver_busy", 64'(rw_result), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid:reset_outputs", 64'(out_vec()), 64'(RESET_VEC));
    @(negedge clk);
    check("rst_mid:reset_held", 64'(out_vec()), 64'(RESET_VEC));
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    start_run("restart");
    wait_idle("restart", 2000);
    check_ref("restart", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
